mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one combinational 4x4 unsigned Wallace multiplier among NREQ requesters.
- Round-robin arbitration selects one request per cycle and drives its operands onto the multiplier.
- The 8-bit product and the winning requester ID are registered into a one-slot response buffer with a valid/ready handshake.
- Sits between operand sources (e.g. the pin-level top) and the shared multiplier instance. The multiplier is external; this block only drives its operands and samples its product.

Parameters:
- NREQ, 4, number of requesters; legal 2..8.
- IDW, 2, width of the requester ID; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  bit i: requester i has an operand pair pending.
- req_ready  out  NREQ  bit i: requester i is accepted this cycle; one-hot or zero.
- req_a  in  4*NREQ  operand A, requester i in bits [4i+3:4i].
- req_b  in  4*NREQ  operand B, requester i in bits [4i+3:4i].
- mul_a  out  4  operand A to the shared multiplier.
- mul_b  out  4  operand B to the shared multiplier.
- mul_prod  in  8  product from the shared multiplier; combinational in mul_a/mul_b.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer accepts the response this cycle.
- rsp_prod  out  8  registered product.
- rsp_id  out  IDW  requester that produced rsp_prod.
- busy  out  1  rsp_valid OR any req_valid; combinational.

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_prod=0, rsp_id=0.
  - Round-robin pointer=0; state=EMPTY.
  - While rst=1, req_ready=0 and mul_a=mul_b=0.
- Response buffer state machine:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - can_accept = (state==EMPTY) OR (rsp_valid AND rsp_ready).
- Arbitration, combinational, every cycle:
  - If can_accept and any req_valid, grant g = first set req_valid bit searching from pointer upward, wrapping modulo NREQ.
  - req_ready[g]=1; all other req_ready bits 0.
  - No grant: req_ready=0 and mul_a=mul_b=0, not left floating or holding old values.
- Datapath on a grant:
  - mul_a = req_a slice g; mul_b = req_b slice g, combinational in the same cycle.
  - At the edge: rsp_prod <= mul_prod, rsp_id <= g, state <= FULL.
  - Pointer <= (g+1) mod NREQ. The pointer advances only on a grant.
- Latency and throughput:
  - Latency is 1 cycle: a request accepted in cycle n appears with rsp_valid=1 in cycle n+1.
  - Sustained throughput is 1 result per cycle while rsp_ready=1.
- State transitions:
  - EMPTY with no grant: stay EMPTY.
  - FULL, rsp_ready=1, no grant: go to EMPTY; rsp_prod and rsp_id keep their last values.
  - FULL, rsp_ready=1, grant: stay FULL and load the new data. Drain and fill in the same cycle, no bubble.
  - FULL, rsp_ready=0: hold rsp_valid, rsp_prod and rsp_id stable; req_ready=0 for all requesters.
- Requester rules:
  - A requester holds req_valid, req_a and req_b stable until req_ready.
  - req_ready may depend on req_valid; req_valid never depends on req_ready.
  - Deasserting req_valid before acceptance is legal; the request is dropped and no response is produced.
- Arithmetic: unsigned 4x4 to 8 bits, no overflow possible; maximum product is 15*15=225 (0xE1). The block does not alter the product.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Reset mid-operation:
  - A buffered response is discarded; rsp_valid drops at the reset edge.
  - A request in flight in the reset cycle is not accepted (req_ready=0).
  - The pointer returns to 0.
- Assertions for the bench:
  - req_ready is onehot0.
  - req_ready[i] implies req_valid[i].
  - rsp_* are stable while rsp_valid and !rsp_ready.

Test Plan:
- Reset check: hold rst for 2 cycles with req_valid=4'b1111 → req_ready=0, rsp_valid=0, mul_a=mul_b=0. After release, the first grant goes to requester 0.
- Single request: requester 2 sends A=3, B=5, rsp_ready=1 → req_ready=4'b0100 in the same cycle. Next cycle rsp_valid=1, rsp_prod=15, rsp_id=2. The following cycle rsp_valid=0.
- Round-robin: all 4 requesters valid with operands (1,1), (2,3), (15,15), (0,9), rsp_ready=1 → responses on consecutive cycles in ID order 0,1,2,3 with products 1, 6, 225, 0.
- Backpressure: rsp_ready=0 for 5 cycles while FULL with rsp_prod=6, with requester 1 pending → rsp_* stable and req_ready=0 throughout. On rsp_ready=1, requester 1 is granted the same cycle and the new result follows with no bubble.
- Exhaustive arithmetic: stream all 256 (A,B) pairs through requester 3 → every rsp_prod equals A*B and rsp_id=3 for all.
- Reset mid-operation: assert rst while FULL with requester 0 pending → rsp_valid=0 the next cycle. After release, requester 0 is reissued and served with the correct product.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end for one shared combinational 4x4 multiplier.
// One grant per cycle; the product and winner ID land in a one-slot valid/ready buffer.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [3:0]        mul_a,
    output logic [3:0]        mul_b,
    input  logic [7:0]        mul_prod,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_prod,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [7:0]     prod;
        logic [IDW-1:0] id;
    } rsp_t;

    state_t               state_q, state_d;
    rsp_t                 rsp_q;
    logic [IDW-1:0]       ptr_q, ptr_d, gnt_id, idx;
    logic                 gnt_vld, can_accept;
    logic [NREQ-1:0][3:0] op_a, op_b;

    for (genvar i = 0; i < NREQ; i++) begin : g_ops
        assign op_a[i] = req_a[4*i +: 4];
        assign op_b[i] = req_b[4*i +: 4];
    end

    // Reset blocks acceptance so nothing in flight during reset gets a grant.
    assign can_accept = !rst && (state_q == EMPTY || rsp_ready);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
        gnt_vld = gnt_vld && can_accept;
        ptr_d   = IDW'((int'(gnt_id) + 1) % NREQ);
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        state_d   = state_q;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
            mul_a             = op_a[gnt_id];
            mul_b             = op_b[gnt_id];
            state_d           = FULL;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_vld) begin
                rsp_q.prod <= mul_prod;
                rsp_q.id   <= gnt_id;
                ptr_q      <= ptr_d;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_prod  = rsp_q.prod;
    assign rsp_id    = rsp_q.id;
    assign busy      = rsp_valid | (|req_valid);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: expected responses are queued at issue
// time and a negedge monitor pops and compares them on each response transfer.
module tb_mult_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [4*NREQ-1:0] req_a, req_b;
    logic [3:0]        mul_a, mul_b;
    logic [7:0]        mul_prod;
    logic              rsp_valid, rsp_ready;
    logic [7:0]        rsp_prod;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    typedef struct {
        logic [7:0]     prod;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // The shared multiplier lives outside the block.
    assign mul_prod = {4'b0, mul_a} * {4'b0, mul_b};

    mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_prod(rsp_prod), .rsp_id(rsp_id), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic push(input logic [7:0] p, input logic [IDW-1:0] id);
        exp_t e;
        e.prod = p;
        e.id   = id;
        sbq.push_back(e);
    endtask

    // Drops each requester's valid once granted; reports the first grant seen.
    task automatic serve(input int budget, output int cycles, output logic [NREQ-1:0] first_gnt);
        logic [NREQ-1:0] gnt;
        cycles    = 0;
        first_gnt = '0;
        while (req_valid != '0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
            gnt = req_ready;
            if (cycles == 1) first_gnt = gnt;
            @(posedge clk); #1;
            req_valid = req_valid & ~gnt;
        end
        if (req_valid != '0) chk("serve_timeout", 32'(req_valid), 32'h0);
    endtask

    // Scoreboard monitor: a transfer happens at the next edge when valid&ready.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_prod), 32'hFFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
    end

    // Protocol checker: grant shape and response stability under backpressure.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_prod;
    logic [1:0] prev_id;
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'h1);
            chk("ready_implies_valid", 32'(req_ready & ~req_valid), 32'h0);
        end
        if (prev_hold) begin
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_prod", 32'(rsp_prod), 32'(prev_prod));
            chk("hold_id", 32'(rsp_id), 32'(prev_id));
        end
        prev_hold = !rst && rsp_valid === 1'b1 && rsp_ready === 1'b0;
        prev_prod = rsp_prod;
        prev_id   = rsp_id;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int              cyc;
        logic [NREQ-1:0] fg;

        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        set_op(0, 4'd1, 4'd1);
        set_op(1, 4'd2, 4'd3);
        set_op(2, 4'd15, 4'd15);
        set_op(3, 4'd0, 4'd9);

        // Reset with every requester pending
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_mul_a", 32'(mul_a), 32'h0);
            chk("rst_mul_b", 32'(mul_b), 32'h0);
            chk("rst_rsp_prod", 32'(rsp_prod), 32'h0);
            chk("rst_rsp_id", 32'(rsp_id), 32'h0);
            chk("rst_busy", 32'(busy), 32'h1);
        end

        // Round robin from pointer 0: products 1, 6, 225, 0
        push(8'd1, 2'd0);
        push(8'd6, 2'd1);
        push(8'd225, 2'd2);
        push(8'd0, 2'd3);
        @(posedge clk); #1;
        rst = 1'b0;
        serve(20, cyc, fg);
        chk("rr_first_grant", 32'(fg), 32'h1);
        chk("rr_cycles", 32'(cyc), 32'd4);
        repeat (2) @(negedge clk);
        chk("rr_idle_valid", 32'(rsp_valid), 32'h0);
        chk("rr_idle_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;

        // Single request from requester 2: 3*5 = 15
        set_op(2, 4'd3, 4'd5);
        req_valid = 4'b0100;
        push(8'd15, 2'd2);
        serve(20, cyc, fg);
        chk("single_grant", 32'(fg), 32'h4);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        chk("single_rsp_gone", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;

        // Backpressure: buffer holds 6 from requester 1 while 5*5 waits
        set_op(1, 4'd2, 4'd3);
        req_valid = 4'b0010;
        push(8'd6, 2'd1);
        push(8'd25, 2'd1);
        @(negedge clk);
        chk("bp_first_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_op(1, 4'd5, 4'd5);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_prod", 32'(rsp_prod), 32'd6);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_refill_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("bp_no_bubble_valid", 32'(rsp_valid), 32'h1);
        chk("bp_no_bubble_prod", 32'(rsp_prod), 32'd25);
        @(posedge clk); #1;

        // All 256 operand pairs through requester 3, one per cycle
        req_valid = 4'b1000;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_op(3, 4'(a), 4'(b));
                push(8'(a * b), 2'd3);
                @(negedge clk);
                chk("exh_grant", 32'(req_ready), 32'h8);
                @(posedge clk); #1;
            end
        end
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while FULL with requester 0 pending again
        rsp_ready = 1'b0;
        set_op(0, 4'd7, 4'd9);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("mid_first_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        set_op(0, 4'd4, 4'd4);
        @(negedge clk);
        chk("mid_full", 32'(rsp_valid), 32'h1);
        chk("mid_blocked", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_mul_a", 32'(mul_a), 32'h0);
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        push(8'd16, 2'd0);
        @(negedge clk);
        chk("mid_dropped", 32'(rsp_valid), 32'h0);
        chk("mid_reissue_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("final_idle", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
